// File: rtl/mmc1_serial_writer_pkg.sv
// Shared types and constants for the MMC1 serial register-load writer.
// Register selects, state encoding and the mapper address/data constants live here.
package mmc1_pkg;

  typedef enum logic [1:0] {
    CTRL = 2'd0,
    CHR0 = 2'd1,
    CHR1 = 2'd2,
    PRG  = 2'd3
  } mmc1_reg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_WR,
    ST_BIT_WR,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [15:0] MMC1_BASE       = 16'h8000;
  localparam logic [7:0]  MMC1_RESET_DATA = 8'h80;
  localparam logic [2:0]  MMC1_BITS       = 3'd5;

  // Bit 15 is always set; bits 14:13 select the mapper register.
  function automatic logic [15:0] reg_addr(input mmc1_reg_e r);
    return MMC1_BASE | {1'b0, r, 13'h0000};
  endfunction

endpackage

// File: rtl/mmc1_serial_writer_if.sv
// Request handshake plus the generated CPU-side bus of the MMC1 writer.
// The requester uses the master view; the writer itself uses the slave view.
interface mmc1_serial_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_reg;
  logic [4:0]  req_data;
  logic        req_reset;
  logic        done;
  logic        m2;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw;

  modport master (
    output req_valid, req_reg, req_data, req_reset,
    input  req_ready, done, m2, cpu_addr, cpu_data, cpu_rw
  );

  modport slave (
    input  req_valid, req_reg, req_data, req_reset,
    output req_ready, done, m2, cpu_addr, cpu_data, cpu_rw
  );
endinterface

// File: rtl/mmc1_serial_writer_m2_gen.sv
// Free-running M2 generator: low phase then high phase, M2_HALF clks each.
// cyc_start marks the clk where the count leaves 0, cyc_end the clk where m2 falls.
module m2_gen #(
  parameter int M2_HALF = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic m2,
  output logic cyc_start,
  output logic cyc_end
);

  localparam int PERIOD = 2 * M2_HALF;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  assign cnt_d     = (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
  assign cyc_start = (cnt == '0);
  assign cyc_end   = (cnt == CW'(PERIOD - 1));

  // m2 is registered from the next count so it is glitch-free yet always equals (cnt >= M2_HALF).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      m2  <= 1'b0;
    end else begin
      cnt <= cnt_d;
      m2  <= (cnt_d >= CW'(M2_HALF));
    end
  end

endmodule

// File: rtl/mmc1_serial_writer.sv
// Emits one MMC1 serial register load as NES CPU write cycles on an M2-timed bus:
// optional reset write, five LSB-first bit writes, GAP idle M2 cycles after each write.
module mmc1_serial_writer
  import mmc1_pkg::*;
#(
  parameter int          M2_HALF   = 3,
  parameter int          GAP       = 1,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmc1_serial_writer_if.slave  bus
);

  localparam logic [2:0] GAP_LAST = 3'(GAP - 1);

  logic m2, cyc_start, cyc_end;

  m2_gen #(.M2_HALF(M2_HALF)) u_m2_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2        (m2),
    .cyc_start (cyc_start),
    .cyc_end   (cyc_end)
  );

  state_e      state, state_d;
  mmc1_reg_e   lreg, lreg_d;
  logic        lrst, lrst_d;
  logic [4:0]  shreg, shreg_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [2:0]  gap_cnt, gap_cnt_d;
  logic        ready, ready_d;
  logic [15:0] addr, addr_d;
  logic [7:0]  data, data_d;
  logic        rw, rw_d;
  logic        start_bit, start_idle;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state;
    lreg_d     = lreg;
    lrst_d     = lrst;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    gap_cnt_d  = gap_cnt;
    ready_d    = ready;
    addr_d     = addr;
    data_d     = data;
    rw_d       = rw;
    start_bit  = 1'b0;
    start_idle = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid && ready) begin
          ready_d   = 1'b0;
          lreg_d    = mmc1_reg_e'(bus.req_reg);
          lrst_d    = bus.req_reset;
          shreg_d   = bus.req_data;
          bit_cnt_d = '0;
        end else if (!ready && cyc_start) begin
          if (lrst) begin
            state_d = ST_RST_WR;
            addr_d  = MMC1_BASE;
            data_d  = MMC1_RESET_DATA;
            rw_d    = 1'b0;
          end else begin
            start_bit = 1'b1;
          end
        end
      end
      ST_RST_WR, ST_BIT_WR: begin
        if (cyc_start) begin
          state_d    = ST_GAP;
          gap_cnt_d  = GAP_LAST;
          start_idle = 1'b1;
        end
      end
      ST_GAP: begin
        // Bit writes begin on a cycle start; completion is flagged as the last idle cycle's m2 falls.
        if (cyc_start && gap_cnt != '0) begin
          gap_cnt_d = gap_cnt - 3'd1;
        end else if (cyc_start && bit_cnt != MMC1_BITS) begin
          start_bit = 1'b1;
        end else if (cyc_end && gap_cnt == '0 && bit_cnt == MMC1_BITS) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_bit) begin
      state_d   = ST_BIT_WR;
      addr_d    = reg_addr(lreg);
      data_d    = {7'b0, shreg[0]};
      rw_d      = 1'b0;
      shreg_d   = shreg >> 1;
      bit_cnt_d = bit_cnt + 3'd1;
    end
    if (start_idle) begin
      addr_d = IDLE_ADDR;
      data_d = '0;
      rw_d   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lreg    <= CTRL;
      lrst    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ready   <= 1'b1;
      addr    <= IDLE_ADDR;
      data    <= '0;
      rw      <= 1'b1;
    end else begin
      state   <= state_d;
      lreg    <= lreg_d;
      lrst    <= lrst_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      ready   <= ready_d;
      addr    <= addr_d;
      data    <= data_d;
      rw      <= rw_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.done      = (state == ST_DONE);
  assign bus.m2        = m2;
  assign bus.cpu_addr  = addr;
  assign bus.cpu_data  = data;
  assign bus.cpu_rw    = rw;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Scoreboard bench for mmc1_serial_writer: the driver queues expected writes and loads,
// a monitor acting as an MMC1 mapper checks the bus at every m2 falling edge.
module tb_mmc1_serial_writer;
  import mmc1_pkg::*;

  localparam int          M2_HALF   = 3;
  localparam int          GAP       = 1;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mmc1_serial_writer_if bus ();

  mmc1_serial_writer #(
    .M2_HALF   (M2_HALF),
    .GAP       (GAP),
    .IDLE_ADDR (IDLE_ADDR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [1:0] r;
    logic [4:0] v;
    bit         rs;
  } load_t;

  wr_t   wr_q[$];
  load_t load_q[$];

  logic [4:0] map_reg[4];
  logic [4:0] map_sr;
  int         map_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / mapper model ----------------
  logic [24:0] p_bus, cur;
  logic        p_m2, p_done;
  int          k, run, idle_since, falls;
  bit          run_valid, have_wr, in_load;
  wr_t         w, e;
  load_t       l;

  always @(negedge clk) begin
    cur = {bus.cpu_addr, bus.cpu_data, bus.cpu_rw};
    if (!rst_n) begin
      check("done_in_reset", bus.done, 1'b0);
      for (int i = 0; i < 4; i++) map_reg[i] = '0;
      map_sr = '0; map_cnt = 0;
      run_valid = 0; run = 0; have_wr = 0; in_load = 0;
      idle_since = 0; falls = 0; k = 2;
      p_bus = cur; p_m2 = bus.m2; p_done = 1'b0;
    end else begin
      if (p_m2 && !bus.m2) k = 0;
      else k++;
      if (k != 1) check("bus_hold", cur, p_bus);

      if (bus.m2 != p_m2) begin
        if (run_valid) check("m2_half", run, M2_HALF);
        run_valid = 1; run = 1;
      end else begin
        run++;
      end

      if (k == 0) begin
        if (in_load) falls++;
        if (!bus.cpu_rw) begin
          w = {bus.cpu_addr, bus.cpu_data};
          if (wr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr", w.addr, e.addr);
            check("wr_data", w.data, e.data);
          end
          if (have_wr) begin
            if (in_load) check("gap_in_load", idle_since, GAP);
            else         check("gap_between", idle_since >= GAP, 1);
          end
          if (!in_load) begin in_load = 1; falls = 1; end
          if (w.data[7]) begin
            map_sr = '0; map_cnt = 0;
          end else begin
            map_sr = {w.data[0], map_sr[4:1]};
            map_cnt++;
            if (map_cnt == 5) begin
              map_reg[w.addr[14:13]] = map_sr;
              map_sr = '0; map_cnt = 0;
            end
          end
          have_wr = 1; idle_since = 0;
        end else begin
          idle_since++;
        end
      end

      if (bus.done) begin
        check("done_width", p_done, 1'b0);
        if (load_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          l = load_q.pop_front();
          check("reg_value", map_reg[l.r], l.v);
          check("m2_cycles", falls, (5 + int'(l.rs)) * (1 + GAP));
          check("writes_left", wr_q.size(), 0);
        end
        in_load = 0;
      end
      p_bus = cur; p_m2 = bus.m2; p_done = bus.done;
    end
  end

  // ---------------- driver ----------------
  task automatic accept(input logic [1:0] r, input logic [4:0] v, input bit rs, input bit keep);
    int    n;
    load_t ld;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    check("no_overlap", load_q.size(), 0);
    bus.req_reg = r; bus.req_data = v; bus.req_reset = rs; bus.req_valid = 1'b1;
    @(posedge clk);
    ld.r = r; ld.v = v; ld.rs = rs;
    load_q.push_back(ld);
    if (rs) wr_q.push_back({16'h8000, 8'h80});
    for (int i = 0; i < 5; i++) wr_q.push_back({1'b1, r, 13'h0000, 7'h00, v[i]});
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((load_q.size() != 0 || !bus.req_ready) && n < 2000) begin @(negedge clk); n++; end
    check("done_timeout", load_q.size(), 0);
  endtask

  initial begin
    int   n, wr_seen;
    logic prev_rw;
    bus.req_valid = 1'b0; bus.req_reg = '0; bus.req_data = '0; bus.req_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rw",    bus.cpu_rw, 1'b1);
    check("rst_addr",  bus.cpu_addr, IDLE_ADDR);
    check("rst_data",  bus.cpu_data, 8'h00);
    check("rst_m2",    bus.m2, 1'b0);
    check("rst_ready", bus.req_ready, 1'b1);
    #1 rst_n = 1'b1;

    // four idle M2 periods
    for (int i = 0; i < 4 * 2 * M2_HALF; i++) begin
      @(negedge clk);
      check("idle_rw",    bus.cpu_rw, 1'b1);
      check("idle_addr",  bus.cpu_addr, IDLE_ADDR);
      check("idle_ready", bus.req_ready, 1'b1);
    end

    accept(2'd3, 5'b01010, 1'b1, 1'b0);
    wait_done();
    check("prg_model", map_reg[3], 5'h0A);

    accept(2'd0, 5'b11111, 1'b0, 1'b0);
    wait_done();
    check("ctrl_model", map_reg[0], 5'h1F);

    // async reset during the third bit write
    accept(2'd2, 5'b10110, 1'b1, 1'b0);
    n = 0; wr_seen = 0; prev_rw = 1'b1;
    while (wr_seen < 4 && n < 2000) begin
      @(negedge clk);
      if (prev_rw && !bus.cpu_rw) wr_seen++;
      prev_rw = bus.cpu_rw; n++;
    end
    check("third_bit_seen", wr_seen, 4);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rw",    bus.cpu_rw, 1'b1);
    check("midrst_addr",  bus.cpu_addr, IDLE_ADDR);
    check("midrst_data",  bus.cpu_data, 8'h00);
    check("midrst_done",  bus.done, 1'b0);
    check("midrst_ready", bus.req_ready, 1'b1);
    wr_q.delete(); load_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    accept(2'd1, 5'h07, 1'b1, 1'b0);
    wait_done();
    check("chr0_model", map_reg[1], 5'h07);

    // req_valid held high across two loads
    accept(2'd2, 5'h13, 1'b0, 1'b1);
    accept(2'd3, 5'h0C, 1'b1, 1'b0);
    wait_done();
    check("chr1_model", map_reg[2], 5'h13);
    check("prg2_model", map_reg[3], 5'h0C);

    for (int t = 0; t < 20; t++) begin
      logic [1:0] r;
      logic [4:0] v;
      bit         rs;
      r  = 2'($urandom_range(0, 3));
      v  = 5'($urandom_range(0, 31));
      rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 15)) @(negedge clk);
      accept(r, v, rs, 1'b0);
      wait_done();
    end

    repeat (20) @(negedge clk);
    check("queues_empty", wr_q.size() + load_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
